// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_pkg
//  Purpose  : Shared types and helpers for the round-robin token arbiter.
//             Provides the arbiter state encoding, the default client count
//             and a width helper for counters and indices.
//  Ports    : none (package)
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package rr_arb_pkg;

    // Arbiter states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Client count of the original fixed token ring.
    localparam int c_default_n_clients = 9;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_eligible.sv
`default_nettype none
// ============================================================================
//  Module   : rr_next_eligible
//  Purpose  : Combinational circular priority search. Finds the first set bit
//             of the eligible vector strictly after the pointer, wrapping
//             modulo N_CLIENTS.
//  Ports    : i_eligible [N_CLIENTS] - eligible clients
//             i_ptr      [IDW]       - search start (excluded from search)
//             o_next     [IDW]       - first eligible index after i_ptr
//             o_found                - high if any such index exists
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module rr_next_eligible
    import rr_arb_pkg::*;
#(
    parameter int N_CLIENTS = c_default_n_clients,
    parameter int IDW       = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] i_eligible,
    input  logic [IDW-1:0]       i_ptr,
    output logic [IDW-1:0]       o_next,
    output logic                 o_found
);

    logic [IDW-1:0] w_cand;

    // Walk offsets 1..N-1 so the candidate index is always reduced modulo N
    // and can never reach an index >= N_CLIENTS.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k < N_CLIENTS; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % N_CLIENTS);
            if (!o_found && i_eligible[w_cand]) begin
                o_next  = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_token_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : rr_token_arbiter_n
//  Purpose  : N-client round-robin token arbiter with a four-phase req/ack
//             handshake, optional skip-to-next-requester scanning and a
//             hold-time monitor.
//  Ports    : clk                 - rising-edge clock
//             rst                 - synchronous active-high reset
//             req  [N_CLIENTS]    - per-client request
//             ack  [N_CLIENTS]    - per-client grant (one-hot or zero)
//             sel  [IDW]          - current pointer index
//             sel_valid           - high while scanning
//             busy                - high while a grant is being set up/held
//             timeout             - one-cycle pulse on hold-limit expiry
//  Macro    : RR_ARB_HOLD_REVOKE_EN - when defined, a timeout revokes the
//             grant and blocks the owner until it lowers its request.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module rr_token_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N_CLIENTS = c_default_n_clients,
    parameter int IDW       = $clog2(N_CLIENTS),
    parameter int SKIP_IDLE = 0,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CLIENTS-1:0] req,
    output logic [N_CLIENTS-1:0] ack,
    output logic [IDW-1:0]       sel,
    output logic                 sel_valid,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                  c_hold_w   = idx_width(MAX_HOLD);
    localparam logic [IDW-1:0]      c_last_idx = IDW'(N_CLIENTS - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD - 1);

    // Modulo-N increment; explicit wrap keeps non-power-of-2 N in range.
    function automatic logic [IDW-1:0] f_wrap_inc(input logic [IDW-1:0] p);
        return (p == c_last_idx) ? '0 : p + IDW'(1);
    endfunction

    arb_state_t              r_state,   w_state_nxt;
    logic [IDW-1:0]          r_ptr,     w_ptr_nxt;
    logic [IDW-1:0]          r_owner,   w_owner_nxt;
    logic [N_CLIENTS-1:0]    r_ack,     w_ack_nxt;
    logic [c_hold_w-1:0]     r_hold,    w_hold_nxt;
    logic                    r_expired, w_expired_nxt;
    logic                    r_timeout, w_timeout_nxt;
    logic [N_CLIENTS-1:0]    r_blocked;
    logic [N_CLIENTS-1:0]    w_eligible;
    logic [IDW-1:0]          w_skip_idx;
    logic                    w_skip_found;

`ifdef RR_ARB_HOLD_REVOKE_EN
    logic [N_CLIENTS-1:0]    w_blocked_nxt;
`else
    assign r_blocked = '0;
`endif

    assign w_eligible = req & ~r_blocked;

    generate
        if (SKIP_IDLE != 0) begin : g_skip
            rr_next_eligible #(
                .N_CLIENTS (N_CLIENTS),
                .IDW       (IDW)
            ) u_next (
                .i_eligible (w_eligible),
                .i_ptr      (r_ptr),
                .o_next     (w_skip_idx),
                .o_found    (w_skip_found)
            );
        end else begin : g_no_skip
            assign w_skip_idx   = '0;
            assign w_skip_found = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_ack_nxt     = r_ack;
        w_hold_nxt    = r_hold;
        w_expired_nxt = r_expired;
        w_timeout_nxt = 1'b0;
`ifdef RR_ARB_HOLD_REVOKE_EN
        // A block is lifted as soon as its client lowers req.
        w_blocked_nxt = r_blocked & req;
`endif
        case (r_state)
            SCAN: begin
                if (w_eligible[r_ptr]) begin
                    w_owner_nxt = r_ptr;
                    w_state_nxt = READY;
                end else if (w_skip_found) begin
                    w_ptr_nxt = w_skip_idx;
                end else begin
                    w_ptr_nxt = f_wrap_inc(r_ptr);
                end
            end
            READY: begin
                // req is deliberately ignored here; a dropped request is
                // seen in the first BUSY cycle and released there.
                w_ack_nxt          = '0;
                w_ack_nxt[r_owner] = 1'b1;
                w_hold_nxt         = '0;
                w_expired_nxt      = 1'b0;
                w_state_nxt        = BUSY;
            end
            BUSY: begin
                if (!req[r_owner]) begin
                    w_ack_nxt     = '0;
                    w_ptr_nxt     = f_wrap_inc(r_owner);
                    w_hold_nxt    = '0;
                    w_expired_nxt = 1'b0;
                    w_state_nxt   = SCAN;
                end else begin
                    if (r_hold != c_hold_max) begin
                        w_hold_nxt = r_hold + c_hold_w'(1);
                    end
                    // The counter saturates, so r_expired keeps the pulse
                    // to a single cycle per grant.
                    if ((r_hold == c_hold_max) && !r_expired) begin
                        w_timeout_nxt = 1'b1;
                        w_expired_nxt = 1'b1;
`ifdef RR_ARB_HOLD_REVOKE_EN
                        w_ack_nxt              = '0;
                        w_blocked_nxt[r_owner] = 1'b1;
                        w_ptr_nxt              = f_wrap_inc(r_owner);
                        w_hold_nxt             = '0;
                        w_expired_nxt          = 1'b0;
                        w_state_nxt            = SCAN;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SCAN;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_ack     <= '0;
            r_hold    <= '0;
            r_expired <= 1'b0;
            r_timeout <= 1'b0;
`ifdef RR_ARB_HOLD_REVOKE_EN
            r_blocked <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_ack     <= w_ack_nxt;
            r_hold    <= w_hold_nxt;
            r_expired <= w_expired_nxt;
            r_timeout <= w_timeout_nxt;
`ifdef RR_ARB_HOLD_REVOKE_EN
            r_blocked <= w_blocked_nxt;
`endif
        end
    end

    assign ack       = r_ack;
    assign sel       = r_ptr;
    assign sel_valid = (r_state == SCAN);
    assign busy      = (r_state == READY) || (r_state == BUSY);
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_token_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_token_arbiter_n
//  Purpose  : Self-checking bench for rr_token_arbiter_n. Two instances
//             (sequential scan, MAX_HOLD=4; skip scan, MAX_HOLD=5) run
//             directed scenarios and random requests against a reference
//             model built from the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_token_arbiter_n;

`ifdef RR_ARB_HOLD_REVOKE_EN
    localparam bit REVOKE = 1'b1;
`else
    localparam bit REVOKE = 1'b0;
`endif
    localparam int N = 9;

    logic       clk;
    logic       rst;
    logic [8:0] req_a, req_b, ack_a, ack_b;
    logic [3:0] sel_a, sel_b;
    logic       sv_a, sv_b, busy_a, busy_b, to_a, to_b;

    logic [8:0] nreq_a, nreq_b;
    logic       nrst;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = looking for a requester, 1 = grant being
    // set up, 2 = grant held. m_held counts elapsed holding cycles.
    int         m_phase [2];
    int         m_ptr   [2];
    int         m_owner [2];
    int         m_held  [2];
    bit         m_to    [2];
    logic [8:0] m_blk   [2];

    rr_token_arbiter_n #(.N_CLIENTS(9), .SKIP_IDLE(0), .MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .ack(ack_a), .sel(sel_a),
        .sel_valid(sv_a), .busy(busy_a), .timeout(to_a)
    );

    rr_token_arbiter_n #(.N_CLIENTS(9), .SKIP_IDLE(1), .MAX_HOLD(5)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .ack(ack_b), .sel(sel_b),
        .sel_valid(sv_b), .busy(busy_b), .timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int d, input logic [8:0] r);
        int         maxh;
        bit         found;
        int         idx;
        logic [8:0] elig;
        logic [8:0] newblk;
        maxh = (d == 0) ? 4 : 5;
        m_to[d] = 1'b0;
        if (rst) begin
            m_phase[d] = 0; m_ptr[d] = 0; m_owner[d] = 0;
            m_held[d] = 0; m_blk[d] = '0;
            return;
        end
        elig   = r & ~m_blk[d];
        newblk = m_blk[d] & r;
        case (m_phase[d])
            0: begin
                if (elig[m_ptr[d]]) begin
                    m_owner[d] = m_ptr[d];
                    m_phase[d] = 1;
                end else begin
                    found = 1'b0;
                    if (d == 1) begin
                        for (int k = 1; k < N; k++) begin
                            idx = (m_ptr[d] + k) % N;
                            if (!found && elig[idx]) begin
                                found = 1'b1;
                                m_ptr[d] = idx;
                            end
                        end
                    end
                    if (!found) m_ptr[d] = (m_ptr[d] + 1) % N;
                end
            end
            1: begin
                m_phase[d] = 2;
                m_held[d]  = 0;
            end
            default: begin
                if (!r[m_owner[d]]) begin
                    m_phase[d] = 0;
                    m_ptr[d]   = (m_owner[d] + 1) % N;
                end else begin
                    if (m_held[d] == maxh - 1) begin
                        m_to[d] = 1'b1;
                        if (REVOKE) begin
                            newblk[m_owner[d]] = 1'b1;
                            m_phase[d] = 0;
                            m_ptr[d]   = (m_owner[d] + 1) % N;
                        end
                    end
                    m_held[d]++;
                end
            end
        endcase
        m_blk[d] = newblk;
    endtask

    task automatic cmp_dut(input string nm, input int d, input logic [8:0] a,
                           input logic [3:0] s, input logic v, input logic b,
                           input logic t);
        logic [8:0] ea;
        ea = (m_phase[d] == 2) ? (9'd1 << m_owner[d]) : 9'd0;
        check({nm, ".ack"},       32'(a), 32'(ea));
        check({nm, ".sel"},       32'(s), 32'(m_ptr[d]));
        check({nm, ".sel_valid"}, 32'(v), 32'(m_phase[d] == 0));
        check({nm, ".busy"},      32'(b), 32'(m_phase[d] != 0));
        check({nm, ".timeout"},   32'(t), 32'(m_to[d]));
        check({nm, ".onehot"},    32'($onehot0(a)), 32'd1);
        check({nm, ".sel_range"}, 32'(s < 4'd9), 32'd1);
    endtask

    // Advance one clock: model and DUT see the same inputs at the edge, new
    // inputs are applied just after, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, req_a);
        model_step(1, req_b);
        #1;
        rst   = nrst;
        req_a = nreq_a;
        req_b = nreq_b;
        @(negedge clk);
        cmp_dut("A", 0, ack_a, sel_a, sv_a, busy_a, to_a);
        cmp_dut("B", 1, ack_b, sel_b, sv_b, busy_b, to_b);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves rst applied; the next tick with nrst=0 enters cycle 0.
    task automatic do_reset();
        nrst = 1'b1; nreq_a = '0; nreq_b = '0;
        ticks(2);
        nrst = 1'b0;
    endtask

    function automatic logic [8:0] rand_req(input logic [8:0] cur);
        logic [8:0] nx;
        nx = cur;
        for (int i = 0; i < N; i++) begin
            if (cur[i]) begin
                if ($urandom_range(5) == 0) nx[i] = 1'b0;
            end else begin
                if ($urandom_range(3) == 0) nx[i] = 1'b1;
            end
        end
        return nx;
    endfunction

    initial begin
        int n_to;
        int n_seen;
        rst = 1'b1; req_a = '0; req_b = '0;
        nrst = 1'b1; nreq_a = '0; nreq_b = '0;

        // Basic grant / release on client 0
        do_reset();
        nreq_a = 9'h001;
        tick();                                    // cycle 0
        check("rst.sel",       32'(sel_a), 32'd0);
        check("rst.sel_valid", 32'(sv_a),  32'd1);
        check("rst.busy",      32'(busy_a), 32'd0);
        check("rst.ack",       32'(ack_a), 32'd0);
        tick();                                    // cycle 1
        check("s1.ready_busy", 32'(busy_a), 32'd1);
        tick();                                    // cycle 2
        check("s1.ack0",       32'(ack_a), 32'h001);
        ticks(2);
        nreq_a = '0;
        tick();                                    // cycle 5
        tick();                                    // cycle 6
        check("s1.release_ack", 32'(ack_a), 32'd0);
        check("s1.release_sel", 32'(sel_a), 32'd1);

        // Lone requester at index 7: stepping versus skipping
        do_reset();
        nreq_a = 9'h080; nreq_b = 9'h080;
        tick();
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) check("s2.skip_sel7",  32'(sel_b), 32'd7);
            if (c == 3) check("s2.skip_ack7",  32'(ack_b), 32'h080);
            if (c == 8) check("s2.step_noack", 32'(ack_a), 32'd0);
            if (c == 9) check("s2.step_ack7",  32'(ack_a), 32'h080);
        end

        // Hold-time expiry on client 2
        do_reset();
        nreq_a = 9'h004;
        tick();
        n_to = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (to_a) n_to++;
        end
        check("s3.timeout_count", 32'(n_to), 32'd1);
        check("s3.ack_after_to",  32'(ack_a), REVOKE ? 32'd0 : 32'h004);
        nreq_a = '0;
        tick();
        nreq_a = 9'h004;
        n_seen = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (ack_a[2]) n_seen++;
        end
        check("s3.regrant", 32'(n_seen != 0), 32'd1);

        // Reset while client 3 holds the grant
        do_reset();
        nreq_a = 9'h008;
        tick();
        ticks(5);                                  // cycle 5
        check("s4.ack3", 32'(ack_a), 32'h008);
        nrst = 1'b1;
        tick();                                    // cycle 6, rst visible
        nrst = 1'b0;
        tick();                                    // cycle 7
        check("s4.ack",       32'(ack_a),  32'd0);
        check("s4.sel",       32'(sel_a),  32'd0);
        check("s4.sel_valid", 32'(sv_a),   32'd1);
        check("s4.busy",      32'(busy_a), 32'd0);

        // One-cycle request pulse at ptr=4
        do_reset();
        tick();
        ticks(3);
        nreq_a = 9'h010;
        tick();                                    // cycle 4
        nreq_a = '0;
        tick();                                    // cycle 5 (READY)
        tick();                                    // cycle 6
        check("s5.ack4", 32'(ack_a), 32'h010);
        tick();                                    // cycle 7
        check("s5.ack_off",   32'(ack_a), 32'd0);
        check("s5.sel5",      32'(sel_a), 32'd5);
        check("s5.sel_valid", 32'(sv_a),  32'd1);

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nrst   = ($urandom_range(299) == 0);
            nreq_a = rand_req(req_a);
            nreq_b = rand_req(req_b);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_token_arbiter_n.md
Name: rr_token_arbiter_n

Overview:
- Parametrised successor to the fixed nine-client token-ring arbiter.
- A single round-robin pointer visits N clients and grants one requester at a time through a req/ack four-phase handshake.
- Adds a skip-to-next-requester mode, a hold-time monitor and an optional forced-revoke path.
- Sits between N client agents and the shared resource; exactly one instance per resource.

Parameters:
- N_CLIENTS, 9, number of clients (2..64).
- IDW, $clog2(N_CLIENTS), width of the pointer/sel index.
- SKIP_IDLE, 0, 0 = pointer steps one client per scan cycle; 1 = pointer jumps to the next requesting client.
- MAX_HOLD, 16, BUSY cycles allowed before timeout (>=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req  in  N_CLIENTS  per-client request; must stay high until ack seen, then client lowers it to release.
- ack  out  N_CLIENTS  per-client grant; at most one bit set (one-hot or zero).
- sel  out  IDW  current pointer index.
- sel_valid  out  1  high while FSM is in SCAN.
- busy  out  1  high in READY or BUSY.
- timeout  out  1  one-cycle pulse on hold-limit expiry.

Behaviour:
- Single clock; reset is synchronous and active-high, sampled on the rising edge of clk. Reset forces: FSM=SCAN, ptr=0, owner=0, ack=0, timeout=0, hold count=0, blocked mask=0.
- After reset: sel=0, sel_valid=1, busy=0.
- Eligible client i means req[i]=1 and blocked[i]=0.
- FSM states: SCAN, READY, BUSY.
- SCAN, ptr eligible: owner<=ptr, go to READY.
- SCAN, ptr not eligible, SKIP_IDLE=0: ptr<=(ptr+1) mod N.
- SCAN, ptr not eligible, SKIP_IDLE=1: ptr<=first eligible index circularly after ptr; if none, ptr<=(ptr+1) mod N.
- READY: lasts exactly one cycle; ack[owner]<=1; go to BUSY. req is ignored in READY.
- BUSY, req[owner]=0: ack<=0, ptr<=(owner+1) mod N, hold count<=0, go to SCAN.
- BUSY, req[owner]=1: hold count increments, saturating at MAX_HOLD-1.
- Grant latency: req visible at ptr in cycle t gives READY at t+1 and ack at t+2.
- Worst-case wait, SKIP_IDLE=0 and no timeouts: (N-1)*(hold+3)+N cycles.
- Timeout: when hold count equals MAX_HOLD-1 in BUSY with req still high, timeout pulses for one cycle. Without the macro, nothing else changes.
- Wrap-around: ptr modulo N_CLIENTS; non-power-of-2 N must never produce an index >= N.
- Simultaneous requests: only ptr position matters; other requesters wait.
- req drop during READY: ack still rises for one cycle, then release in the following BUSY cycle.
- Reset mid-grant: ack drops on the reset edge; no release handshake required.
- Invariants: $onehot0(ack); ack!=0 only in BUSY; sel_valid and busy mutually exclusive.

Optional Feature:
- Macro: RR_ARB_HOLD_REVOKE_EN.
- Defined: on timeout, ack[owner]<=0, blocked[owner]<=1, ptr<=(owner+1) mod N, go to SCAN in the same edge. blocked[i] clears on any cycle req[i]=0, so a revoked client is not re-granted until it cycles req.
- Undefined: blocked mask is tied to 0; timeout is only an advisory pulse and the grant is held indefinitely.

Decomposition:
- Shared package rr_arb_pkg: typedef enum arb_state_t {SCAN, READY, BUSY}; localparam helpers for IDW.
- One sub-module, rr_next_eligible: combinational circular priority search (inputs eligible vector and ptr; outputs next index and found flag). Used only when SKIP_IDLE=1.

Test Plan:
- N=9, SKIP_IDLE=0, reset then req[0]=1 at cycle 0 -> READY cycle 1, ack[0]=1 at cycle 2; drop req at cycle 5 -> ack=0 at cycle 6, sel=1.
- N=9, SKIP_IDLE=0, req[7] only -> sel steps 0..7, ack[7] at cycle 9; SKIP_IDLE=1, same stimulus -> sel=7 at cycle 1, ack[7] at cycle 3.
- N=5, all req held, each client releases 2 cycles after ack -> grant order 0,1,2,3,4,0; ack one-hot every cycle; sel never >=5.
- MAX_HOLD=4, client 2 holds req -> timeout pulse exactly once. With RR_ARB_HOLD_REVOKE_EN: ack[2] drops that edge and client 2 is not re-granted until req[2] toggles low. Without it: ack[2] stays high.
- Assert rst while ack[3]=1 -> next cycle ack=0, sel=0, sel_valid=1, busy=0.
- req[4] pulsed high for one cycle while ptr=4 -> READY, ack[4] for one cycle, then SCAN with sel=5.
